alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multi-cycle issue controller: the driving end of the 3-bit ALU op interface.
- Accepts one 32-bit MIPS instruction per valid/ready handshake and decodes it into an ALU op and an operand-B select.
- Sequences read, execute and write-back over fixed states, then returns the register write-back and zero flag.
- Sits between instruction fetch and the register file / logic ALU in the multi-cycle datapath.

Parameters:
- ENABLE_LUI, 1, when 0 the LUI opcode decodes as illegal.
- STRICT_SHAMT, 1, when 1 an R-type logic op with shamt != 0 is illegal.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept.
- instr  in  32  instruction word.
- rs_addr  out  5  register-file read port A address.
- rt_addr  out  5  register-file read port B address.
- alu_op  out  3  ALU op: 000 AND, 001 OR, 010 NOR, 011 XOR, 100 LUI (b<<16).
- alu_src_imm  out  1  1 = ALU operand B is imm_ext; 0 = operand B is the rt register.
- imm_ext  out  32  zero-extended instr[15:0].
- alu_y  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- wb_en  out  1  register write strobe.
- wb_addr  out  5  destination register.
- wb_data  out  32  write data.
- zero_flag  out  1  alu_zero of the last completed op.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, DECODE, EXEC, WB.
- Reset (resetn low at a clk edge), including mid-operation: state goes to IDLE and all outputs clear to 0, except instr_ready which is 1 while resetn is high. zero_flag is cleared. No wb_en pulse is produced for an aborted instruction.
- IDLE: instr_ready = 1. When instr_valid && instr_ready, latch instr and go to DECODE. instr_ready is 0 in every other state; no skid buffer.
- DECODE:
  - Drive rs_addr = instr[25:21] and rt_addr = instr[20:16].
  - Register the decoded alu_op, alu_src_imm, destination and imm_ext.
  - Illegal instruction: pulse illegal for exactly one cycle and go to IDLE; no EXEC, no wb_en.
  - Legal instruction: go to EXEC.
- Decode table:
  - R-type (opcode 000000), destination rd = instr[15:11], alu_src_imm = 0:
    - funct 100100 AND -> 000
    - funct 100101 OR -> 001
    - funct 100111 NOR -> 010
    - funct 100110 XOR -> 011
  - I-type, destination rt, alu_src_imm = 1:
    - 001100 ANDI -> 000
    - 001101 ORI -> 001
    - 001110 XORI -> 011
    - 001111 LUI -> 100
  - Instruction 0x00000000 is a NOP: it goes through EXEC and WB with wb_en held low. It is not illegal and does not update zero_flag.
  - Everything else is illegal, plus the parameter-gated cases (ENABLE_LUI = 0 for LUI; STRICT_SHAMT = 1 with shamt != 0 on an R-type logic op).
- EXEC:
  - alu_op and alu_src_imm are stable for the whole cycle.
  - At the end of the cycle, capture alu_y into wb_data and alu_zero into the zero_flag staging register, then go to WB.
- WB:
  - wb_en = 1 for exactly one cycle with wb_addr and wb_data valid.
  - wb_en is suppressed when the destination is register 0 or the instruction is a NOP. zero_flag still updates for register 0; it does not update for a NOP.
  - Next state is IDLE.
- Throughput and latency:
  - One instruction per 4 cycles.
  - wb_en asserts 3 cycles after the accepting edge.
  - An instruction held valid in WB is accepted on the next IDLE cycle.
- alu_op holds its last value while IDLE; downstream only samples in EXEC.
- imm_ext = {16'b0, instr[15:0]} for all I-type ops. The ALU performs the LUI shift.

Decomposition:
- Shared package / header `alu_defs`:
  - ALU op constants: ALUOP_AND = 3'b000, ALUOP_OR = 3'b001, ALUOP_NOR = 3'b010, ALUOP_XOR = 3'b011, ALUOP_LUI = 3'b100.
  - Opcode and funct constants.
  - State encoding.
- One combinational sub-module, `alu_op_decode`: instr -> {alu_op, alu_src_imm, dst_sel, is_nop, illegal}.
- The FSM and registers live in the top module.

Test Plan:
- Reset: hold resetn = 0 for 2 clks -> busy = 0, wb_en = 0, illegal = 0, zero_flag = 0, and instr_ready = 1 once resetn is high.
- ORI $t1,$zero,0x00F0 (0x340900F0) with model ALU a = 0 -> alu_op = 001, alu_src_imm = 1, imm_ext = 0x000000F0. Drive alu_y = 0x000000F0, alu_zero = 0 -> wb_en 3 cycles after accept, wb_addr = 9, wb_data = 0x000000F0, zero_flag = 0.
- R-type XOR $3,$1,$2 (0x00221826) with alu_y = 0 -> alu_op = 011, alu_src_imm = 0, rs_addr = 1, rt_addr = 2, wb_addr = 3, zero_flag = 1 after WB.
- LUI $4,0x1234 (0x3C041234) -> alu_op = 100, imm_ext = 0x00001234. Rerun with ENABLE_LUI = 0 -> illegal pulses 1 cycle in DECODE, wb_en never asserts, instr_ready returns the next cycle.
- Edge cases:
  - Write to $0 (AND $0,$1,$2) -> no wb_en, zero_flag updated.
  - NOP 0x00000000 -> no wb_en, no illegal.
  - Back-to-back valid -> accepts exactly 4 cycles apart.
- Reset mid-op: assert resetn = 0 during EXEC -> next cycle IDLE, no wb_en for that instruction, next instruction processed normally.

Source files
------------

// File: rtl/alu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_defs (package)
//  Purpose  : Shared constants for the ALU issue controller: ALU op codes,
//             MIPS opcode/funct values and the controller state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_defs;

    // 3-bit ALU op interface
    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_NOR = 3'b010;
    localparam logic [2:0] ALUOP_XOR = 3'b011;
    localparam logic [2:0] ALUOP_LUI = 3'b100;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // Destination select: rt field for I-type, rd field for R-type
    localparam logic DST_RT = 1'b0;
    localparam logic DST_RD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

endpackage : alu_defs
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Purpose  : Combinational decode of a MIPS logic instruction into the ALU
//             op, operand-B select, destination field select and NOP/illegal
//             classification.
//  Ports    : instr       - 32-bit instruction word
//             alu_op      - 3-bit ALU op
//             alu_src_imm - 1 = operand B is the immediate
//             dst_sel     - DST_RD (R-type) or DST_RT (I-type)
//             is_nop      - instruction is the all-zero NOP
//             illegal     - instruction cannot be executed
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_defs::*;
#(
    parameter bit ENABLE_LUI   = 1'b1,
    parameter bit STRICT_SHAMT = 1'b1
) (
    input  logic [31:0] instr,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        dst_sel,
    output logic        is_nop,
    output logic        illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_shamt;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_shamt  = instr[10:6];

    always_comb begin
        alu_op      = ALUOP_AND;
        alu_src_imm = 1'b0;
        dst_sel     = DST_RT;
        is_nop      = 1'b0;
        illegal     = 1'b0;

        if (instr == 32'h0000_0000) begin
            // The all-zero word would otherwise fall into the R-type
            // illegal-funct path; it is a real NOP targeting $0.
            is_nop  = 1'b1;
            dst_sel = DST_RD;
        end else begin
            case (w_opcode)
                OPC_RTYPE: begin
                    dst_sel = DST_RD;
                    case (w_funct)
                        FUNCT_AND: alu_op = ALUOP_AND;
                        FUNCT_OR:  alu_op = ALUOP_OR;
                        FUNCT_NOR: alu_op = ALUOP_NOR;
                        FUNCT_XOR: alu_op = ALUOP_XOR;
                        default:   illegal = 1'b1;
                    endcase
                    if (STRICT_SHAMT && (w_shamt != 5'd0)) begin
                        illegal = 1'b1;
                    end
                end
                OPC_ANDI: begin
                    alu_op      = ALUOP_AND;
                    alu_src_imm = 1'b1;
                end
                OPC_ORI: begin
                    alu_op      = ALUOP_OR;
                    alu_src_imm = 1'b1;
                end
                OPC_XORI: begin
                    alu_op      = ALUOP_XOR;
                    alu_src_imm = 1'b1;
                end
                OPC_LUI: begin
                    alu_op      = ALUOP_LUI;
                    alu_src_imm = 1'b1;
                    if (!ENABLE_LUI) begin
                        illegal = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Multi-cycle issue controller driving the 3-bit ALU op interface.
//             Accepts one instruction per valid/ready handshake and sequences
//             IDLE -> DECODE -> EXEC -> WB, returning register write-back and
//             the zero flag of the last completed op.
//  Ports    : clk, resetn            - clock, synchronous active-low reset
//             instr_valid/ready/instr - instruction handshake
//             rs_addr, rt_addr       - register-file read addresses
//             alu_op, alu_src_imm,
//             imm_ext                - ALU control and immediate operand
//             alu_y, alu_zero        - ALU result and zero flag
//             wb_en, wb_addr, wb_data - register write-back
//             zero_flag              - zero flag of last completed op
//             illegal                - one-cycle undecodable pulse (DECODE)
//             busy                   - controller not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_defs::*;
#(
    parameter bit ENABLE_LUI   = 1'b1,
    parameter bit STRICT_SHAMT = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic [31:0] imm_ext,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        zero_flag,
    output logic        illegal,
    output logic        busy
);

    state_e      r_state;
    state_e      w_state_nxt;

    logic [31:0] r_instr;
    logic [2:0]  r_alu_op;
    logic        r_alu_src_imm;
    logic [4:0]  r_dst;
    logic [31:0] r_imm_ext;
    logic        r_is_nop;
    logic [31:0] r_wb_data;
    logic        r_zero_stage;
    logic        r_zero_flag;

    logic [2:0]  w_dec_op;
    logic        w_dec_src_imm;
    logic        w_dec_dst_sel;
    logic        w_dec_is_nop;
    logic        w_dec_illegal;

    alu_op_decode #(
        .ENABLE_LUI   (ENABLE_LUI),
        .STRICT_SHAMT (STRICT_SHAMT)
    ) u_decode (
        .instr       (r_instr),
        .alu_op      (w_dec_op),
        .alu_src_imm (w_dec_src_imm),
        .dst_sel     (w_dec_dst_sel),
        .is_nop      (w_dec_is_nop),
        .illegal     (w_dec_illegal)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        illegal     = 1'b0;
        wb_en       = 1'b0;
        busy        = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy        = 1'b0;
                // Ready is gated by resetn so nothing is accepted during reset.
                instr_ready = resetn;
                if (instr_valid) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (w_dec_illegal) begin
                    illegal     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                wb_en       = !r_is_nop && (r_dst != 5'd0);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_instr       <= 32'h0;
            r_alu_op      <= ALUOP_AND;
            r_alu_src_imm <= 1'b0;
            r_dst         <= 5'd0;
            r_imm_ext     <= 32'h0;
            r_is_nop      <= 1'b0;
            r_wb_data     <= 32'h0;
            r_zero_stage  <= 1'b0;
            r_zero_flag   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                    end
                end
                ST_DECODE: begin
                    r_alu_op      <= w_dec_op;
                    r_alu_src_imm <= w_dec_src_imm;
                    r_dst         <= (w_dec_dst_sel == DST_RD) ? r_instr[15:11]
                                                               : r_instr[20:16];
                    r_imm_ext     <= {16'h0000, r_instr[15:0]};
                    r_is_nop      <= w_dec_is_nop;
                end
                ST_EXEC: begin
                    r_wb_data    <= alu_y;
                    r_zero_stage <= alu_zero;
                end
                ST_WB: begin
                    // Flag commits only when the op completes, so an aborted
                    // instruction never disturbs it; $0 writes still count.
                    if (!r_is_nop) begin
                        r_zero_flag <= r_zero_stage;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read addresses come straight from the latched word and stay valid
    // through EXEC while the register file feeds the ALU.
    assign rs_addr     = r_instr[25:21];
    assign rt_addr     = r_instr[20:16];
    assign alu_op      = r_alu_op;
    assign alu_src_imm = r_alu_src_imm;
    assign imm_ext     = r_imm_ext;
    assign wb_addr     = r_dst;
    assign wb_data     = r_wb_data;
    assign zero_flag   = r_zero_flag;

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Directed self-checking bench for alu_issue_ctrl. A second
//             instance built with ENABLE_LUI = 0 covers the gated LUI decode.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk;
    logic        resetn;
    logic        instr_valid;
    logic        instr_valid_nl;
    logic [31:0] instr;
    logic [31:0] alu_y;
    logic        alu_zero;

    logic        instr_ready, instr_ready_nl;
    logic [4:0]  rs_addr, rt_addr, rs_addr_nl, rt_addr_nl;
    logic [2:0]  alu_op, alu_op_nl;
    logic        alu_src_imm, alu_src_imm_nl;
    logic [31:0] imm_ext, imm_ext_nl;
    logic        wb_en, wb_en_nl;
    logic [4:0]  wb_addr, wb_addr_nl;
    logic [31:0] wb_data, wb_data_nl;
    logic        zero_flag, zero_flag_nl;
    logic        illegal, illegal_nl;
    logic        busy, busy_nl;

    int n_checks;
    int n_errors;

    alu_issue_ctrl #(.ENABLE_LUI(1'b1), .STRICT_SHAMT(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .zero_flag(zero_flag), .illegal(illegal), .busy(busy)
    );

    alu_issue_ctrl #(.ENABLE_LUI(1'b0), .STRICT_SHAMT(1'b1)) u_dut_nolui (
        .clk(clk), .resetn(resetn), .instr_valid(instr_valid_nl),
        .instr_ready(instr_ready_nl), .instr(instr),
        .rs_addr(rs_addr_nl), .rt_addr(rt_addr_nl), .alu_op(alu_op_nl),
        .alu_src_imm(alu_src_imm_nl), .imm_ext(imm_ext_nl),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .wb_en(wb_en_nl), .wb_addr(wb_addr_nl), .wb_data(wb_data_nl),
        .zero_flag(zero_flag_nl), .illegal(illegal_nl), .busy(busy_nl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Offer ins to the main instance and return at the negedge of DECODE.
    task automatic accept_main(input string tag, input logic [31:0] ins);
        bit got;
        got = 1'b0;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (instr_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_val({tag, "_accept_timeout"}, {31'd0, got}, 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    // Full legal instruction through the main instance, checked per stage.
    task automatic run_op(input string tag, input logic [31:0] ins,
                          input logic [31:0] y, input logic z,
                          input logic [4:0] e_rs, input logic [4:0] e_rt,
                          input logic [2:0] e_op, input logic e_src,
                          input logic [31:0] e_imm, input logic e_wben,
                          input logic [4:0] e_addr, input logic e_zf);
        alu_y    = y;
        alu_zero = z;
        accept_main(tag, ins);
        // DECODE
        chk_val({tag, "_busy"},    {31'd0, busy},    32'd1);
        chk_val({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
        chk_val({tag, "_rs"},      {27'd0, rs_addr}, {27'd0, e_rs});
        chk_val({tag, "_rt"},      {27'd0, rt_addr}, {27'd0, e_rt});
        @(negedge clk);
        // EXEC
        chk_val({tag, "_alu_op"},  {29'd0, alu_op},  {29'd0, e_op});
        chk_val({tag, "_src_imm"}, {31'd0, alu_src_imm}, {31'd0, e_src});
        if (e_src) chk_val({tag, "_imm_ext"}, imm_ext, e_imm);
        chk_val({tag, "_exec_wben"}, {31'd0, wb_en}, 32'd0);
        @(negedge clk);
        // WB: third cycle after the accepting edge
        chk_val({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, e_wben});
        if (e_wben) begin
            chk_val({tag, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, e_addr});
            chk_val({tag, "_wb_data"}, wb_data, y);
        end
        @(negedge clk);
        // back in IDLE
        chk_val({tag, "_zero_flag"}, {31'd0, zero_flag}, {31'd0, e_zf});
        chk_val({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk_val({tag, "_idle_ready"}, {31'd0, instr_ready}, 32'd1);
    endtask

    // Illegal instruction through the main instance.
    task automatic run_illegal(input string tag, input logic [31:0] ins);
        bit seen_wb;
        seen_wb = 1'b0;
        accept_main(tag, ins);
        chk_val({tag, "_illegal"}, {31'd0, illegal}, 32'd1);
        @(negedge clk);
        chk_val({tag, "_illegal_len"}, {31'd0, illegal}, 32'd0);
        chk_val({tag, "_ready_back"}, {31'd0, instr_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (wb_en) seen_wb = 1'b1;
            @(negedge clk);
        end
        chk_val({tag, "_no_wb"}, {31'd0, seen_wb}, 32'd0);
    endtask

    initial begin
        int  first, second;
        bit  seen_wb, got;
        n_checks       = 0;
        n_errors       = 0;
        resetn         = 1'b0;
        instr_valid    = 1'b0;
        instr_valid_nl = 1'b0;
        instr          = 32'h0;
        alu_y          = 32'h0;
        alu_zero       = 1'b0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_val("rst_busy",      {31'd0, busy},      32'd0);
        chk_val("rst_wb_en",     {31'd0, wb_en},     32'd0);
        chk_val("rst_illegal",   {31'd0, illegal},   32'd0);
        chk_val("rst_zero_flag", {31'd0, zero_flag}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk_val("rst_ready", {31'd0, instr_ready}, 32'd1);

        // ORI $t1,$zero,0x00F0
        run_op("ori", 32'h3409_00F0, 32'h0000_00F0, 1'b0,
               5'd0, 5'd9, 3'b001, 1'b1, 32'h0000_00F0, 1'b1, 5'd9, 1'b0);
        // XOR $3,$1,$2 with zero result
        run_op("xor", 32'h0022_1826, 32'h0000_0000, 1'b1,
               5'd1, 5'd2, 3'b011, 1'b0, 32'h0, 1'b1, 5'd3, 1'b1);
        // LUI $4,0x1234
        run_op("lui", 32'h3C04_1234, 32'h1234_0000, 1'b0,
               5'd0, 5'd4, 3'b100, 1'b1, 32'h0000_1234, 1'b1, 5'd4, 1'b0);
        // AND $0,$1,$2: no write, zero flag still updates
        run_op("and_r0", 32'h0022_0024, 32'h0000_0000, 1'b1,
               5'd1, 5'd2, 3'b000, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        // NOP with alu_zero low: flag keeps its previous 1
        run_op("nop", 32'h0000_0000, 32'h0000_0000, 1'b0,
               5'd0, 5'd0, 3'b000, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        // NOR $7,$1,$2
        run_op("nor", 32'h0022_3827, 32'hFFFF_0000, 1'b0,
               5'd1, 5'd2, 3'b010, 1'b0, 32'h0, 1'b1, 5'd7, 1'b0);

        // Illegal: ADDI opcode, and AND with nonzero shamt
        run_illegal("addi", 32'h2001_0005);
        run_illegal("shamt", 32'h0022_2864);

        // ---------------- LUI on the ENABLE_LUI = 0 instance ----------------
        got = 1'b0;
        seen_wb = 1'b0;
        @(negedge clk);
        instr          = 32'h3C04_1234;
        instr_valid_nl = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (instr_ready_nl) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk_val("nolui_accept_timeout", {31'd0, got}, 32'd1);
        @(negedge clk);
        instr_valid_nl = 1'b0;
        chk_val("nolui_illegal", {31'd0, illegal_nl}, 32'd1);
        @(negedge clk);
        chk_val("nolui_illegal_len", {31'd0, illegal_nl}, 32'd0);
        chk_val("nolui_ready_back", {31'd0, instr_ready_nl}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            if (wb_en_nl) seen_wb = 1'b1;
            @(negedge clk);
        end
        chk_val("nolui_no_wb", {31'd0, seen_wb}, 32'd0);

        // ---------------- back-to-back valid ----------------
        first  = -1;
        second = -1;
        alu_y    = 32'h0000_00F0;
        alu_zero = 1'b0;
        instr       = 32'h3409_00F0;
        instr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (instr_ready) begin
                if (first < 0) first = c;
                else begin
                    second = c;
                    break;
                end
            end
            @(negedge clk);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        chk_val("b2b_gap", second - first, 32'd4);
        repeat (4) @(negedge clk);

        // ---------------- reset during EXEC ----------------
        seen_wb  = 1'b0;
        alu_y    = 32'hDEAD_BEEF;
        alu_zero = 1'b1;
        accept_main("rst_mid", 32'h340A_0055);
        @(negedge clk);                // EXEC
        resetn = 1'b0;
        @(negedge clk);                // reset taken at the EXEC edge
        chk_val("rst_mid_busy",  {31'd0, busy},  32'd0);
        chk_val("rst_mid_wb_en", {31'd0, wb_en}, 32'd0);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (wb_en) seen_wb = 1'b1;
            @(negedge clk);
        end
        chk_val("rst_mid_no_wb", {31'd0, seen_wb}, 32'd0);
        chk_val("rst_mid_zf",    {31'd0, zero_flag}, 32'd0);
        run_op("post_rst", 32'h380B_00AA, 32'h0000_00AA, 1'b0,
               5'd0, 5'd11, 3'b011, 1'b1, 32'h0000_00AA, 1'b1, 5'd11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_issue_ctrl
`default_nettype wire
